// File: rtl/uop_sequencer_if.sv
// Handshake bundle between fetch, the micro-op sequencer and the translate/decode side.
interface uop_sequencer_if #(
    parameter int MAX_UOPS = 4,
    parameter int STAGE_W  = $clog2(MAX_UOPS)
);
    logic               inst_valid;
    logic               inst_ready;
    logic [47:0]        inst;
    logic               mode;
    logic               uop_valid;
    logic               uop_ready;
    logic [47:0]        held_inst;
    logic               held_mode;
    logic [STAGE_W-1:0] stage;
    logic [STAGE_W:0]   uop_count;
    logic               last;

    modport master (
        output inst_valid, inst, mode, uop_ready,
        input  inst_ready, uop_valid, held_inst, held_mode, stage, uop_count, last
    );

    modport slave (
        input  inst_valid, inst, mode, uop_ready,
        output inst_ready, uop_valid, held_inst, held_mode, stage, uop_count, last
    );
endinterface

// File: rtl/uop_sequencer.sv
// Holds one fetched instruction and replays it to decode as 1..MAX_UOPS micro-ops.
//   state  | meaning
//   S_IDLE | nothing held, ready for fetch
//   S_BUSY | instruction held, issuing uop number 'stage'
module uop_sequencer #(
    parameter int MAX_UOPS    = 4,
    parameter int STAGE_W     = $clog2(MAX_UOPS),
    parameter bit SPLIT_POPL  = 1'b1,
    parameter bit SPLIT_PUSHL = 1'b0,
    parameter bit SPLIT_RET   = 1'b0,
    parameter int R_ESP       = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    uop_sequencer_if.slave    bus
);
    localparam logic [0:0]         S_IDLE  = 1'b0;
    localparam logic [0:0]         S_BUSY  = 1'b1;
    localparam logic [STAGE_W:0]   CNT_ONE = (STAGE_W+1)'(1);
    localparam logic [STAGE_W:0]   CNT_TWO = (STAGE_W+1)'(2);
    localparam logic [STAGE_W:0]   CNT_MAX = (STAGE_W+1)'(MAX_UOPS);
    localparam logic [STAGE_W-1:0] STG_ONE = STAGE_W'(1);
    localparam logic [4:0]         ESP_REG = 5'(R_ESP);

    logic [0:0]         state;
    logic [STAGE_W-1:0] stage_q;
    logic [STAGE_W:0]   count_q;
    logic [47:0]        inst_q;
    logic               mode_q;
    logic [STAGE_W:0]   count_raw;
    logic [STAGE_W:0]   count_new;
    logic [4:0]         ra_int;
    logic               last_w;
    logic               ready_w;
    logic               accept;

    // Y86 register fields are 0-based; the core numbers registers from 1.
    always_comb begin
        count_raw = CNT_ONE;
        ra_int    = {1'b0, bus.inst[15:12]} + 5'd1;
        if (bus.mode) begin
            case (bus.inst[7:4])
                4'hB: if (SPLIT_POPL && ra_int != ESP_REG) count_raw = CNT_TWO;
                4'hA: if (SPLIT_PUSHL) count_raw = CNT_TWO;
                4'h9: if (SPLIT_RET) count_raw = CNT_TWO;
                default: count_raw = CNT_ONE;
            endcase
        end
        count_new = (count_raw > CNT_MAX) ? CNT_MAX : count_raw;
    end

    assign last_w  = ({1'b0, stage_q} == (count_q - CNT_ONE));
    assign ready_w = !flush && (state == S_IDLE || (bus.uop_ready && last_w));
    assign accept  = bus.inst_valid && ready_w;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            stage_q <= '0;
            count_q <= CNT_ONE;
            inst_q  <= '0;
            mode_q  <= 1'b0;
        end else if (flush) begin
            state   <= S_IDLE;
            stage_q <= '0;
        end else if (accept) begin
            state   <= S_BUSY;
            stage_q <= '0;
            count_q <= count_new;
            inst_q  <= bus.inst;
            mode_q  <= bus.mode;
        end else if (state == S_BUSY && bus.uop_ready) begin
            if (last_w) begin
                state   <= S_IDLE;
                stage_q <= '0;
            end else begin
                stage_q <= stage_q + STG_ONE;
            end
        end
    end

    assign bus.inst_ready = ready_w;
    assign bus.uop_valid  = (state == S_BUSY);
    assign bus.held_inst  = inst_q;
    assign bus.held_mode  = mode_q;
    assign bus.stage      = stage_q;
    assign bus.uop_count  = count_q;
    assign bus.last       = last_w;
endmodule

// File: tb/tb_uop_sequencer.sv
// Scoreboard bench for uop_sequencer: two configurations driven by the same stimulus.
module tb_uop_sequencer;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        flush = 1'b0;
    logic        inst_valid = 1'b0;
    logic        uop_ready = 1'b0;
    logic [47:0] inst = '0;
    logic        mode = 1'b0;
    bit          mon_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [47:0] inst;
        logic        mode;
        int          stage;
        int          cnt;
    } exp_t;

    exp_t q[2][$];

    always #5 clk = ~clk;

    uop_sequencer_if #(.MAX_UOPS(4)) ifa ();
    uop_sequencer_if #(.MAX_UOPS(2)) ifb ();

    assign ifa.inst_valid = inst_valid;
    assign ifa.inst       = inst;
    assign ifa.mode       = mode;
    assign ifa.uop_ready  = uop_ready;
    assign ifb.inst_valid = inst_valid;
    assign ifb.inst       = inst;
    assign ifb.mode       = mode;
    assign ifb.uop_ready  = uop_ready;

    uop_sequencer #(.MAX_UOPS(4), .SPLIT_POPL(1'b1), .SPLIT_PUSHL(1'b0), .SPLIT_RET(1'b0), .R_ESP(5))
        dut_a (.clk(clk), .resetn(resetn), .flush(flush), .bus(ifa));
    uop_sequencer #(.MAX_UOPS(2), .SPLIT_POPL(1'b0), .SPLIT_PUSHL(1'b1), .SPLIT_RET(1'b1), .R_ESP(5))
        dut_b (.clk(clk), .resetn(resetn), .flush(flush), .bus(ifb));

    // Reference: how many uops an instruction needs under configuration d.
    function automatic int model_count(input logic [47:0] i, input logic m, input int d);
        int  n;
        bit  sp_popl, sp_push, sp_ret;
        int  max_u;
        sp_popl = (d == 0);
        sp_push = (d == 1);
        sp_ret  = (d == 1);
        max_u   = (d == 0) ? 4 : 2;
        n = 1;
        if (m) begin
            if (i[7:4] == 4'hB && sp_popl && (int'(i[15:12]) + 1) != 5) n = 2;
            if (i[7:4] == 4'hA && sp_push) n = 2;
            if (i[7:4] == 4'h9 && sp_ret) n = 2;
        end
        if (n > max_u) n = max_u;
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int d, input bit v, input bit ir, input logic [47:0] hi, input bit hm,
                        input int st, input int cnt, input bit lst);
        bit   exp_rdy;
        bit   exp_last;
        exp_t e;
        int   n;
        exp_last = 1'b0;
        if (q[d].size() != 0) exp_last = (q[d][0].stage == q[d][0].cnt - 1);
        exp_rdy = !flush && (q[d].size() == 0 || (uop_ready && exp_last));
        n_cmp++;
        if (ir != exp_rdy) begin
            n_bad++;
            $display("FAIL inst_ready dut%0d @%0t: got %0b want %0b", d, $time, ir, exp_rdy);
        end
        n_cmp++;
        if (v != (q[d].size() != 0)) begin
            n_bad++;
            $display("FAIL uop_valid dut%0d @%0t: got %0b want %0b", d, $time, v, q[d].size() != 0);
        end else if (v) begin
            e = q[d][0];
            n_cmp++;
            if (hi !== e.inst || hm !== e.mode || st != e.stage || cnt != e.cnt || lst != exp_last) begin
                n_bad++;
                $display("FAIL uop dut%0d @%0t: got inst=%h mode=%0b stage=%0d cnt=%0d last=%0b want inst=%h mode=%0b stage=%0d cnt=%0d last=%0b",
                         d, $time, hi, hm, st, cnt, lst, e.inst, e.mode, e.stage, e.cnt, exp_last);
            end
        end else begin
            chk($sformatf("idle_stage dut%0d", d), st, 0);
        end
        if (flush) q[d].delete();
        else if (q[d].size() != 0 && uop_ready) void'(q[d].pop_front());
        if (inst_valid && exp_rdy) begin
            n = model_count(inst, mode, d);
            for (int s = 0; s < n; s++) q[d].push_back('{inst, mode, s, n});
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            step(0, ifa.uop_valid, ifa.inst_ready, ifa.held_inst, ifa.held_mode,
                 int'(ifa.stage), int'(ifa.uop_count), ifa.last);
            step(1, ifb.uop_valid, ifb.inst_ready, ifb.held_inst, ifb.held_mode,
                 int'(ifb.stage), int'(ifb.uop_count), ifb.last);
        end
    end

    task automatic drive(input bit iv, input logic [47:0] ins, input bit md, input bit ur, input bit fl);
        inst_valid = iv;
        inst       = ins;
        mode       = md;
        uop_ready  = ur;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] rand_inst();
        logic [47:0] r;
        r[47:32] = 16'($urandom);
        r[31:0]  = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            r[7:4]   = 4'($urandom_range(9, 11));
            r[15:12] = 4'($urandom_range(0, 7));
        end
        return r;
    endfunction

    localparam logic [47:0] MIPS_ADD = 48'h0000_0022_1820;
    localparam logic [47:0] POPL_EAX = 48'h0000_0000_0FB0;
    localparam logic [47:0] POPL_ESP = 48'h0000_0000_4FB0;
    localparam logic [47:0] PUSHL    = 48'h0000_0000_0FA0;
    localparam logic [47:0] RET      = 48'h0000_0000_0090;
    localparam logic [47:0] IRMOVL   = 48'h1234_5678_F030;

    initial begin
        #1 resetn = 1'b0;
        #2;
        chk("rst uop_valid", int'(ifa.uop_valid), 0);
        chk("rst last", int'(ifa.last), 1);
        chk("rst inst_ready", int'(ifa.inst_ready), 1);
        chk("rst stage", int'(ifa.stage), 0);
        chk("rst uop_count", int'(ifa.uop_count), 1);
        chk("rst held_inst_zero", int'(ifa.held_inst == '0), 1);
        chk("rst held_mode", int'(ifa.held_mode), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        mon_en = 1'b1;

        drive(1, MIPS_ADD, 0, 1, 0);
        drive(0, '0, 0, 1, 0);
        drive(1, POPL_EAX, 1, 1, 0);
        repeat (2) drive(0, '0, 0, 1, 0);
        drive(1, POPL_ESP, 1, 1, 0);
        drive(1, PUSHL, 1, 1, 0);
        drive(1, RET, 1, 1, 0);
        repeat (3) drive(0, '0, 0, 1, 0);
        drive(1, POPL_EAX, 1, 0, 0);
        repeat (3) drive(0, '0, 0, 0, 0);
        repeat (2) drive(0, '0, 0, 1, 0);
        drive(1, IRMOVL, 1, 1, 0);
        drive(1, POPL_EAX, 1, 1, 0);
        repeat (3) drive(0, '0, 0, 1, 0);
        drive(1, POPL_EAX, 1, 1, 0);
        drive(1, MIPS_ADD, 0, 1, 1);
        drive(1, MIPS_ADD, 0, 1, 0);
        repeat (2) drive(0, '0, 0, 1, 0);

        for (int c = 0; c < 3000; c++)
            drive($urandom_range(0, 3) != 0, rand_inst(), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);

        repeat (4) drive(0, '0, 0, 1, 0);
        drive(1, POPL_EAX, 1, 1, 0);
        drive(0, '0, 0, 1, 0);
        drive(0, '0, 0, 0, 0);
        chk("mid stage before reset", int'(ifa.stage), 1);
        #3;
        mon_en = 1'b0;
        resetn = 1'b0;
        #1;
        chk("async rst uop_valid", int'(ifa.uop_valid), 0);
        chk("async rst stage", int'(ifa.stage), 0);
        chk("async rst inst_ready", int'(ifa.inst_ready), 1);
        chk("async rst uop_count", int'(ifa.uop_count), 1);
        q[0].delete();
        q[1].delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        mon_en = 1'b1;
        drive(1, PUSHL, 1, 1, 0);
        repeat (3) drive(0, '0, 0, 1, 0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uop_sequencer.md
Name: uop_sequencer

Overview:
- Generalised micro-op sequencer between instruction fetch and the translate control unit of the dual-mode MIPS/Y86 core.
- Latches one fetched instruction and holds it while the decoder issues it as one or more micro-ops.
- Presents the held instruction with a stage index and a last flag, under valid/ready handshakes on both sides.
- Replaces the fixed single-bit popl stage flop with a parametrised counter, configurable split rules and flush support.

Parameters:
MAX_UOPS, 4, maximum micro-ops per instruction; must be >= 2.
STAGE_W, $clog2(MAX_UOPS), width of the stage counter.
SPLIT_POPL, 1, popl with rA != %esp issues 2 uops (load, then esp+4).
SPLIT_PUSHL, 0, pushl issues 2 uops (store at esp-4, then esp-=4).
SPLIT_RET, 0, ret issues 2 uops (load target, then esp+=4).
R_ESP, 5, internal register number of %esp (Y86 reg index + 1).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_valid  in  1  fetch presents an instruction
inst_ready  out  1  sequencer accepts this cycle
inst  in  48  raw instruction (MIPS in [31:0]; Y86 op [7:4], rA [15:12])
mode  in  1  0 = MIPS, 1 = Y86
flush  in  1  discard the held instruction (redirect)
uop_valid  out  1  held instruction valid for decode
uop_ready  in  1  downstream consumed the current uop
held_inst  out  48  latched instruction
held_mode  out  1  latched mode
stage  out  STAGE_W  index of the current uop, 0-based
uop_count  out  STAGE_W+1  total uops for the held instruction
last  out  1  stage == uop_count-1

Behaviour:
- Reset (async, resetn=0): occupied=0, stage=0, held_inst=0, held_mode=0, uop_count=1. Outputs follow: uop_valid=0, last=1, inst_ready=1.
- Count table, evaluated on the incoming inst/mode at acceptance and registered into uop_count:
  - mode 0: 1.
  - Y86 popl (op 4'hB): 2 if SPLIT_POPL and rA+1 != R_ESP, else 1.
  - Y86 pushl (4'hA): 2 if SPLIT_PUSHL, else 1.
  - Y86 ret (4'h9): 2 if SPLIT_RET, else 1.
  - All other ops, including undefined: 1.
  - Any count > MAX_UOPS is clamped to MAX_UOPS.
- uop_valid = occupied.
- inst_ready = !flush & (!occupied | (uop_ready & last)), combinational. This gives back-to-back issue with no bubble.
- Accept = inst_valid & inst_ready. On accept: latch inst, mode and count; set stage=0 and occupied=1.
- Advance (occupied & uop_ready & !flush):
  - if !last: stage += 1.
  - if last and no accept: occupied=0, stage=0.
  - if last and accept: the new instruction loads in the same edge.
- If uop_ready=0, stage and held_* hold indefinitely; held outputs stay stable while uop_valid=1.
- flush=1: on the next edge occupied=0, stage=0, whether or not the instruction was mid-sequence. No accept happens in the flush cycle. held_inst and held_mode keep their last value (don't-care while invalid).
- The stage counter never exceeds uop_count-1 and never wraps.
- Reset asserted mid-sequence aborts immediately: state returns to reset values asynchronously.
- Latency: an accepted instruction's stage 0 is visible the cycle after acceptance.

Test Plan:
- MIPS add (mode 0, inst=32'h00221820), uop_ready=1 -> uop_valid for 1 cycle, stage=0, last=1, uop_count=1; inst_ready stays 1.
- Y86 popl %eax (mode 1, inst[15:0]=16'h0FB0) -> 2 uops: stage 0 (last=0), then stage 1 (last=1); inst_ready=0 during stage 0 and 1 during stage 1.
- popl %esp (inst[15:0]=16'h4FB0) -> uop_count=1, single uop. With SPLIT_PUSHL=1, pushl (16'h0FA0) -> uop_count=2.
- Backpressure: popl held with uop_ready=0 for 3 cycles -> stage stays 0, held_inst unchanged; back-to-back irmovl then popl with uop_ready=1 -> no idle cycle between them.
- Flush during popl stage 0 with inst_valid=1 -> inst_ready=0 that cycle; next cycle uop_valid=0, stage=0; the following instruction is accepted afterwards.
- resetn pulsed low mid popl at stage 1 -> uop_valid=0, stage=0 immediately, without waiting for a clock edge.
